// File: rtl/iomem_wb_pkg.sv
// Shared types and constants for the picosoc iomem to Wishbone classic bridge.
// Holds the FSM state encoding, the default error data word and the timer width helper.
package iomem_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   // Wide enough to hold TIMEOUT_CYCLES-1, the largest value the timer ever reaches.
   function automatic int timer_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/iomem_wb_master_if.sv
// Wishbone classic bus between the iomem bridge (master) and wb_hyperram (slave).
// Signal names keep the master-side _o/_i suffixes so both ends read the same way.
interface iomem_wb_master_if;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_addr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i, wbm_err_i
   );

endinterface

// File: rtl/iomem_wb_timer.sv
// Bus watchdog counter: cleared when a request is accepted, counts while the cycle is open.
// tc_o flags the last cycle the bridge is allowed to wait for an acknowledge.
module iomem_wb_timer
   import iomem_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk_20M,
   input  logic resetn,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int             CNT_W  = timer_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at the terminal count so a stalled enable can never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TC_VAL)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_20M) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/iomem_wb_master.sv
// Registered Wishbone classic master for one iomem address window, one transaction at a time.
// A watchdog ends any cycle the slave never acknowledges so the CPU is always released.
module iomem_wb_master
   import iomem_wb_pkg::*;
#(
   parameter logic [7:0]  ADDR_MATCH     = 8'h30,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic                      clk_20M,
   input  logic                      resetn,

   input  logic                      iomem_valid,
   input  logic [3:0]                iomem_wstrb,
   input  logic [31:0]               iomem_addr,
   input  logic [31:0]               iomem_wdata,
   output logic                      iomem_ready,
   output logic [31:0]               iomem_rdata,
   output logic                      hit_o,

   iomem_wb_master_if.master         wbm,

   input  logic                      err_clr_i,
   output logic                      timeout_o,
   output logic                      error_o
);

   state_e      state_q, state_d;
   logic        cyc_q, cyc_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] dat_q, dat_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        timeout_q, timeout_d;
   logic        error_q, error_d;

   logic        tmr_clr;
   logic        tmr_en;
   logic        tmr_tc;
   logic        term;
   logic [31:0] term_data;

   assign hit_o = iomem_valid && (iomem_addr[31:24] == ADDR_MATCH);

   iomem_wb_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk_20M (clk_20M),
      .resetn  (resetn),
      .clr_i   (tmr_clr),
      .en_i    (tmr_en),
      .tc_o    (tmr_tc)
   );

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      dat_d     = dat_q;
      ready_d   = 1'b0;
      rdata_d   = rdata_q;
      timeout_d = err_clr_i ? 1'b0 : timeout_q;
      error_d   = err_clr_i ? 1'b0 : error_q;
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      term      = 1'b0;
      term_data = ERR_DATA;

      unique case (state_q)
         IDLE: begin
            if (hit_o) begin
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = |iomem_wstrb;
               sel_d   = (|iomem_wstrb) ? iomem_wstrb : 4'hF;
               addr_d  = iomem_addr;
               dat_d   = iomem_wdata;
               tmr_clr = 1'b1;
               state_d = BUS;
            end
         end

         BUS: begin
            tmr_en = 1'b1;
            // Ack outranks err, and a real slave answer outranks the watchdog.
            if (wbm.wbm_ack_i) begin
               term      = 1'b1;
               term_data = we_q ? 32'h0 : wbm.wbm_dat_i;
            end else if (wbm.wbm_err_i) begin
               term      = 1'b1;
               error_d   = 1'b1;
            end else if (tmr_tc) begin
               term      = 1'b1;
               timeout_d = 1'b1;
            end

            if (term) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               state_d = RESP;
               // A CPU that already withdrew its request gets neither a ready nor new data.
               ready_d = iomem_valid;
               if (iomem_valid) begin
                  rdata_d = term_data;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_20M) begin
      // NOTE: resetn is synchronous, so it is tested inside the clocked block and never appears in the sensitivity list.
      if (!resetn) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'h0;
         addr_q    <= 32'h0;
         dat_q     <= 32'h0;
         ready_q   <= 1'b0;
         rdata_q   <= 32'h0;
         timeout_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         dat_q     <= dat_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         timeout_q <= timeout_d;
         error_q   <= error_d;
      end
   end

   assign wbm.wbm_cyc_o  = cyc_q;
   assign wbm.wbm_stb_o  = stb_q;
   assign wbm.wbm_we_o   = we_q;
   assign wbm.wbm_sel_o  = sel_q;
   assign wbm.wbm_addr_o = addr_q;
   assign wbm.wbm_dat_o  = dat_q;

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign timeout_o   = timeout_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_iomem_wb_master.sv
// Directed bench for iomem_wb_master: read, write, timeout, non-hit, err/ack priority,
// withdrawn request and mid-cycle reset, with hand-computed expectations at each step.
module tb_iomem_wb_master;

   localparam int TMO = 16;

   logic        clk_20M;
   logic        resetn;
   logic        iomem_valid;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic        iomem_ready;
   logic [31:0] iomem_rdata;
   logic        hit_o;
   logic        err_clr_i;
   logic        timeout_o;
   logic        error_o;

   int checks = 0;
   int errors = 0;

   iomem_wb_master_if wb_bus ();

   iomem_wb_master #(
      .ADDR_MATCH     (8'h30),
      .TIMEOUT_CYCLES (TMO),
      .ERR_DATA       (32'hDEAD_BEEF)
   ) dut (
      .clk_20M     (clk_20M),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_ready (iomem_ready),
      .iomem_rdata (iomem_rdata),
      .hit_o       (hit_o),
      .wbm         (wb_bus),
      .err_clr_i   (err_clr_i),
      .timeout_o   (timeout_o),
      .error_o     (error_o)
   );

   initial clk_20M = 1'b0;
   always #25 clk_20M = ~clk_20M;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Each call lands mid-cycle: outputs are stable, and inputs set here are sampled at the next posedge.
   task automatic next_cycle();
      @(negedge clk_20M);
   endtask

   task automatic request(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = wstrb;
      iomem_wdata = wdata;
   endtask

   initial begin
      resetn             = 1'b0;
      iomem_valid        = 1'b0;
      iomem_wstrb        = 4'h0;
      iomem_addr         = 32'h0;
      iomem_wdata        = 32'h0;
      err_clr_i          = 1'b0;
      wb_bus.wbm_dat_i   = 32'h0;
      wb_bus.wbm_ack_i   = 1'b0;
      wb_bus.wbm_err_i   = 1'b0;

      repeat (3) next_cycle();
      check("rst_cyc",     {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
      check("rst_stb",     {31'h0, wb_bus.wbm_stb_o}, 32'h0);
      check("rst_we",      {31'h0, wb_bus.wbm_we_o},  32'h0);
      check("rst_sel",     {28'h0, wb_bus.wbm_sel_o}, 32'h0);
      check("rst_addr",    wb_bus.wbm_addr_o,         32'h0);
      check("rst_dat",     wb_bus.wbm_dat_o,          32'h0);
      check("rst_ready",   {31'h0, iomem_ready},      32'h0);
      check("rst_rdata",   iomem_rdata,               32'h0);
      check("rst_timeout", {31'h0, timeout_o},        32'h0);
      check("rst_error",   {31'h0, error_o},          32'h0);
      resetn = 1'b1;
      next_cycle();

      // Read, slave acks in cycle 3.
      request(32'h3000_0010, 4'h0, 32'h0);
      #1 check("rd_hit", {31'h0, hit_o}, 32'h1);
      next_cycle(); // cycle 1
      check("rd_c1_cyc", {31'h0, wb_bus.wbm_cyc_o}, 32'h1);
      check("rd_c1_stb", {31'h0, wb_bus.wbm_stb_o}, 32'h1);
      check("rd_c1_we",  {31'h0, wb_bus.wbm_we_o},  32'h0);
      check("rd_c1_sel", {28'h0, wb_bus.wbm_sel_o}, 32'hF);
      check("rd_c1_adr", wb_bus.wbm_addr_o,         32'h3000_0010);
      next_cycle(); // cycle 2
      check("rd_c2_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h1);
      check("rd_c2_ready", {31'h0, iomem_ready},      32'h0);
      next_cycle(); // cycle 3
      check("rd_c3_cyc", {31'h0, wb_bus.wbm_cyc_o}, 32'h1);
      wb_bus.wbm_ack_i = 1'b1;
      wb_bus.wbm_dat_i = 32'h1234_5678;
      next_cycle(); // cycle 4
      check("rd_c4_ready", {31'h0, iomem_ready},      32'h1);
      check("rd_c4_rdata", iomem_rdata,               32'h1234_5678);
      check("rd_c4_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
      wb_bus.wbm_ack_i = 1'b0;
      iomem_valid      = 1'b0;
      next_cycle(); // cycle 5
      check("rd_c5_ready", {31'h0, iomem_ready}, 32'h0);

      // Write with immediate ack.
      request(32'h3000_0004, 4'b0011, 32'hAABB_CCDD);
      next_cycle(); // cycle 1
      check("wr_we",  {31'h0, wb_bus.wbm_we_o},  32'h1);
      check("wr_sel", {28'h0, wb_bus.wbm_sel_o}, 32'h3);
      check("wr_dat", wb_bus.wbm_dat_o,          32'hAABB_CCDD);
      check("wr_adr", wb_bus.wbm_addr_o,         32'h3000_0004);
      wb_bus.wbm_ack_i = 1'b1;
      wb_bus.wbm_dat_i = 32'h5555_AAAA;
      next_cycle(); // cycle 2
      check("wr_ready", {31'h0, iomem_ready}, 32'h1);
      check("wr_rdata", iomem_rdata,          32'h0);
      wb_bus.wbm_ack_i = 1'b0;
      iomem_valid      = 1'b0;
      next_cycle();

      // Read with no ack: watchdog releases the CPU in cycle TMO+1.
      request(32'h3000_0020, 4'h0, 32'h0);
      for (int c = 1; c <= TMO; c++) begin
         next_cycle();
         check("tmo_wait_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h1);
         check("tmo_wait_ready", {31'h0, iomem_ready},      32'h0);
      end
      next_cycle(); // cycle 17
      check("tmo_ready", {31'h0, iomem_ready},      32'h1);
      check("tmo_rdata", iomem_rdata,               32'hDEAD_BEEF);
      check("tmo_flag",  {31'h0, timeout_o},        32'h1);
      check("tmo_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
      iomem_valid = 1'b0;
      next_cycle(); // cycle 18: late ack
      wb_bus.wbm_ack_i = 1'b1;
      wb_bus.wbm_dat_i = 32'h0000_0055;
      next_cycle(); // cycle 19
      check("late_ack_ready", {31'h0, iomem_ready},      32'h0);
      check("late_ack_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
      check("late_ack_rdata", iomem_rdata,               32'hDEAD_BEEF);
      check("late_ack_err",   {31'h0, error_o},          32'h0);
      check("late_ack_tmo",   {31'h0, timeout_o},        32'h1);
      wb_bus.wbm_ack_i = 1'b0;
      err_clr_i        = 1'b1;
      next_cycle();
      check("tmo_cleared", {31'h0, timeout_o}, 32'h0);
      err_clr_i = 1'b0;

      // Non-hit request (GPIO window) is ignored.
      request(32'h0300_0000, 4'h0, 32'h0);
      #1 check("miss_hit", {31'h0, hit_o}, 32'h0);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         check("miss_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
         check("miss_ready", {31'h0, iomem_ready},      32'h0);
      end
      iomem_valid = 1'b0;
      next_cycle();

      // ack and err together: ack wins.
      request(32'h3000_0030, 4'h0, 32'h0);
      next_cycle();
      wb_bus.wbm_ack_i = 1'b1;
      wb_bus.wbm_err_i = 1'b1;
      wb_bus.wbm_dat_i = 32'h1357_9BDF;
      next_cycle();
      check("both_ready", {31'h0, iomem_ready}, 32'h1);
      check("both_rdata", iomem_rdata,          32'h1357_9BDF);
      check("both_error", {31'h0, error_o},     32'h0);
      wb_bus.wbm_ack_i = 1'b0;
      wb_bus.wbm_err_i = 1'b0;
      iomem_valid      = 1'b0;
      next_cycle();

      // err alone.
      request(32'h3000_0034, 4'h0, 32'h0);
      next_cycle();
      wb_bus.wbm_err_i = 1'b1;
      wb_bus.wbm_dat_i = 32'h2468_ACE0;
      next_cycle();
      check("err_ready", {31'h0, iomem_ready}, 32'h1);
      check("err_rdata", iomem_rdata,          32'hDEAD_BEEF);
      check("err_flag",  {31'h0, error_o},     32'h1);
      wb_bus.wbm_err_i = 1'b0;
      iomem_valid      = 1'b0;
      next_cycle();

      // Request withdrawn mid-cycle: no ready, previous rdata kept.
      request(32'h3000_0038, 4'h0, 32'h0);
      next_cycle(); // cycle 1
      iomem_valid = 1'b0;
      next_cycle(); // cycle 2
      wb_bus.wbm_ack_i = 1'b1;
      wb_bus.wbm_dat_i = 32'h7777_0000;
      next_cycle(); // cycle 3 (RESP)
      check("drop_ready", {31'h0, iomem_ready},      32'h0);
      check("drop_rdata", iomem_rdata,               32'hDEAD_BEEF);
      check("drop_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
      wb_bus.wbm_ack_i = 1'b0;
      next_cycle();

      // Reset in cycle 2 of a pending read; error_o is still set from above.
      request(32'h3000_0040, 4'h0, 32'h0);
      next_cycle(); // cycle 1
      check("rstmid_c1_cyc", {31'h0, wb_bus.wbm_cyc_o}, 32'h1);
      next_cycle(); // cycle 2
      resetn      = 1'b0;
      iomem_valid = 1'b0;
      next_cycle(); // cycle 3
      check("rstmid_cyc",   {31'h0, wb_bus.wbm_cyc_o}, 32'h0);
      check("rstmid_stb",   {31'h0, wb_bus.wbm_stb_o}, 32'h0);
      check("rstmid_ready", {31'h0, iomem_ready},      32'h0);
      check("rstmid_error", {31'h0, error_o},          32'h0);
      resetn = 1'b1;
      next_cycle();
      check("rstmid_ready2", {31'h0, iomem_ready}, 32'h0);

      // Fresh read after reset completes normally.
      request(32'h3000_0044, 4'h0, 32'h0);
      next_cycle();
      check("fresh_cyc", {31'h0, wb_bus.wbm_cyc_o}, 32'h1);
      wb_bus.wbm_ack_i = 1'b1;
      wb_bus.wbm_dat_i = 32'hCAFE_F00D;
      next_cycle();
      check("fresh_ready", {31'h0, iomem_ready}, 32'h1);
      check("fresh_rdata", iomem_rdata,          32'hCAFE_F00D);
      wb_bus.wbm_ack_i = 1'b0;
      iomem_valid      = 1'b0;
      next_cycle();
      check("fresh_done", {31'h0, iomem_ready}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iomem_wb_master.md
# iomem_wb_master

Bridges the picosoc native iomem bus (valid/ready) to a registered Wishbone classic master port that drives wb_hyperram directly. It decodes one address window, holds a single outstanding transaction, and registers all Wishbone outputs. A bus-timeout watchdog guarantees the CPU is always released. It replaces the combinational glue currently feeding the HyperRAM slave.

## Interface

Parameters:
- ADDR_MATCH, 8'h30: value of iomem_addr[31:24] that selects this bridge.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for wbm_ack_i; legal range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout or wbm_err_i.

Ports:
- Clocking and reset (already decided): reset resetn, synchronous, active-low; clock clk_20M.
- clk_20M, input, 1: clock.
- resetn, input, 1: reset.
- iomem_valid, input, 1: CPU request valid.
- iomem_wstrb, input, 4: byte write strobes; 0 means read.
- iomem_addr, input, 32: byte address.
- iomem_wdata, input, 32: write data.
- iomem_ready, output, 1: one-cycle completion pulse.
- iomem_rdata, output, 32: read data, valid while iomem_ready=1.
- hit_o, output, 1: combinational; iomem_valid && addr[31:24]==ADDR_MATCH. Used by the top-level read mux.
- wbm_cyc_o, output, 1: Wishbone cycle.
- wbm_stb_o, output, 1: Wishbone strobe.
- wbm_we_o, output, 1: Wishbone write enable.
- wbm_sel_o, output, 4: byte selects.
- wbm_addr_o, output, 32: address.
- wbm_dat_o, output, 32: write data.
- wbm_dat_i, input, 32: read data.
- wbm_ack_i, input, 1: acknowledge.
- wbm_err_i, input, 1: error; tie to 0 if unused.
- err_clr_i, input, 1: clears timeout_o and error_o.
- timeout_o, output, 1: sticky; set when a transaction timed out.
- error_o, output, 1: sticky; set when wbm_err_i terminated a transaction.

## Operation

- FSM states: IDLE, BUS, RESP.
- IDLE:
  - When hit_o=1, capture addr, wdata, and wstrb into the output registers.
  - we = |wstrb. sel = wstrb for writes, 4'hF for reads.
  - Clear the timeout counter and go to BUS.
- BUS:
  - cyc and stb are high. The counter increments every cycle.
  - On wbm_ack_i: latch rdata = we ? 0 : wbm_dat_i, drop cyc/stb, go to RESP.
  - Else on wbm_err_i: latch rdata = ERR_DATA, set error_o, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: latch rdata = ERR_DATA, set timeout_o, go to RESP.
  - If ack and err arrive together, ack wins.
- RESP:
  - iomem_ready = iomem_valid for this single cycle; go to IDLE.
  - If iomem_valid has already dropped (protocol violation), suppress ready and discard the result.
- Late ack or err after the cycle has ended is ignored, because cyc is low.
- Sticky flags: err_clr_i clears them. A set event in the same cycle as err_clr_i wins.
- Wishbone outputs stay stable for the whole BUS state. Address and data are never modified mid-cycle.
- Non-hit requests are ignored entirely.

## Timing

- All outputs are registered except hit_o.
- Reset values: cyc, stb, we = 0; sel = 0; addr, dat_o = 0; iomem_ready = 0; iomem_rdata = 0; timeout_o, error_o = 0; state = IDLE.
- Cycle sequence:
  - Cycle 0: IDLE samples the request.
  - Cycle 1: cyc/stb high.
  - Cycle k (k≥1): ack sampled.
  - Cycle k+1: iomem_ready high.
  - Cycle k+2: back in IDLE, ready for a new request.
- Minimum latency, valid→ready: 2 cycles, with ack in the first BUS cycle.
- Timeout: ready asserts exactly TIMEOUT_CYCLES+1 cycles after the request is sampled.
- A new request whose valid stays high after RESP is accepted in the following IDLE cycle. The CPU normally drops valid the cycle after ready.
- resetn low mid-BUS: cyc/stb are low at the next edge, no ready is issued, and the flags clear.

## Structure

- Package iomem_wb_pkg holds:
  - the state enum typedef (IDLE, BUS, RESP);
  - the ERR_DATA default constant;
  - a function computing the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- One sub-module, iomem_wb_timer: a clear/enable counter with a terminal-count output.

## Test plan

- Read at 0x3000_0010, slave acks in cycle 3 with 0x1234_5678 → cyc/stb high cycles 1–3, sel=4'hF, we=0; iomem_rdata=0x1234_5678 with ready in cycle 4.
- Write wstrb=4'b0011, wdata=0xAABB_CCDD at 0x3000_0004, immediate ack → we=1, sel=4'b0011, dat_o=0xAABB_CCDD; ready in cycle 2, rdata=0.
- Read with no ack, TIMEOUT_CYCLES=16 → ready in cycle 17, rdata=0xDEAD_BEEF, timeout_o=1. Ack injected in cycle 18 is ignored. err_clr_i clears the flag.
- Request at 0x0300_0000 (GPIO window) → hit_o=0, no cyc, iomem_ready stays 0.
- resetn pulsed low in cycle 2 of a pending read → cyc=0 next edge, no ready pulse; a fresh read then completes normally.
- wbm_err_i and wbm_ack_i together in the same cycle → ack data returned, error_o stays 0. err_i alone → ERR_DATA and error_o=1.
